// File: rtl/ppc_types_pkg.sv
// Shared PowerPC core types used by the execution units and the common result bus.
package ppc_types;

    localparam int unsigned RB_RS_ID_WIDTH = 5;

    // CR0 field bits (lt, gt, eq, so) plus the XER flags an instruction can update
    typedef struct packed {
        logic [0:3] cr0;
        logic       so;
        logic       ov;
        logic       ca;
    } cond_exception_t;

    typedef struct packed {
        logic [0:RB_RS_ID_WIDTH-1] rs_id;
        logic [0:4]                reg_addr;
        logic [0:31]               result;
        cond_exception_t           cr0_xer;
    } result_bus_t;

    // Successor index with an explicit wrap, valid for any n (not only powers of two)
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/result_bus_arbiter_rr_arbiter.sv
// Combinational N-way arbiter: round-robin from ptr when RESULT_BUS_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with the lowest index winning.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [0:N-1]         req,
`ifdef RESULT_BUS_ROUND_ROBIN_EN
    input  logic [$clog2(N)-1:0] ptr,
`endif
    output logic [0:N-1]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any
);

    localparam int unsigned IDX_W = $clog2(N);

    // Scan candidates in priority order; the first requester found wins
    always_comb begin
        int unsigned idx;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
`ifdef RESULT_BUS_ROUND_ROBIN_EN
            idx = 32'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
`else
            idx = k;
`endif
            if (!any && req[IDX_W'(idx)]) begin
                any       = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
        if (any) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/result_bus_arbiter.sv
// Arbitrates execution-unit results onto the single registered result bus.
// RESULT_BUS_ROUND_ROBIN_EN selects round-robin; default build is fixed priority.
module result_bus_arbiter
    import ppc_types::*;
#(
    parameter int unsigned UNITS       = 4,
    parameter int unsigned RS_ID_WIDTH = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [0:UNITS-1]                      unit_valid,
    output logic [0:UNITS-1]                      unit_ready,
    input  logic [0:UNITS-1][0:RS_ID_WIDTH-1]     unit_rs_id,
    input  logic [0:UNITS-1][0:4]                 unit_reg_addr,
    input  logic [0:UNITS-1][0:31]                unit_result,
    input  cond_exception_t [0:UNITS-1]           unit_cr0_xer,
    output logic                                  cdb_valid,
    input  logic                                  cdb_ready,
    output logic [0:RS_ID_WIDTH-1]                cdb_rs_id,
    output logic [0:4]                            cdb_reg_addr,
    output logic [0:31]                           cdb_result,
    output cond_exception_t                       cdb_cr0_xer,
    output logic [0:$clog2(UNITS)-1]              cdb_src
);

    localparam int unsigned IDX_W = $clog2(UNITS);

    logic [0:UNITS-1] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             any_req;
    logic             load_c;

`ifdef RESULT_BUS_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;
`endif

    rr_arbiter #(
        .N(UNITS)
    ) u_arb (
        .req      (unit_valid),
`ifdef RESULT_BUS_ROUND_ROBIN_EN
        .ptr      (rr_ptr),
`endif
        .grant    (grant),
        .grant_idx(grant_idx),
        .any      (any_req)
    );

    // Register is empty or draining this cycle, so it can take a new entry
    assign load_c = !cdb_valid || cdb_ready;

    // Reset also blocks acceptance so nothing is handshaken into a register held clear
    always_comb begin
        unit_ready = '0;
        if (rst && load_c) begin
            unit_ready = grant;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid    <= 1'b0;
            cdb_rs_id    <= '0;
            cdb_reg_addr <= '0;
            cdb_result   <= '0;
            cdb_cr0_xer  <= '0;
            cdb_src      <= '0;
        end else if (load_c) begin
            if (any_req) begin
                cdb_valid    <= 1'b1;
                cdb_rs_id    <= unit_rs_id[grant_idx];
                cdb_reg_addr <= unit_reg_addr[grant_idx];
                cdb_result   <= unit_result[grant_idx];
                cdb_cr0_xer  <= unit_cr0_xer[grant_idx];
                cdb_src      <= grant_idx;
            end else begin
                cdb_valid    <= 1'b0;
            end
        end
    end

`ifdef RESULT_BUS_ROUND_ROBIN_EN
    // Pointer moves just past the winner; it only advances on a transfer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (load_c && any_req) begin
            rr_ptr <= IDX_W'(rr_next(32'(grant_idx), UNITS));
        end
    end
`endif

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Directed self-checking bench for result_bus_arbiter (both arbitration builds).
module tb_result_bus_arbiter;
    import ppc_types::*;

`ifdef RESULT_BUS_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [0:3]            unit_valid;
    logic [0:3]            unit_ready;
    logic [0:3][0:4]       unit_rs_id;
    logic [0:3][0:4]       unit_reg_addr;
    logic [0:3][0:31]      unit_result;
    cond_exception_t [0:3] unit_cr0_xer;
    logic                  cdb_valid;
    logic                  cdb_ready;
    logic [0:4]            cdb_rs_id;
    logic [0:4]            cdb_reg_addr;
    logic [0:31]           cdb_result;
    cond_exception_t       cdb_cr0_xer;
    logic [0:1]            cdb_src;

    int total = 0;
    int bad   = 0;

    result_bus_arbiter #(.UNITS(4), .RS_ID_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .unit_valid   (unit_valid),
        .unit_ready   (unit_ready),
        .unit_rs_id   (unit_rs_id),
        .unit_reg_addr(unit_reg_addr),
        .unit_result  (unit_result),
        .unit_cr0_xer (unit_cr0_xer),
        .cdb_valid    (cdb_valid),
        .cdb_ready    (cdb_ready),
        .cdb_rs_id    (cdb_rs_id),
        .cdb_reg_addr (cdb_reg_addr),
        .cdb_result   (cdb_result),
        .cdb_cr0_xer  (cdb_cr0_xer),
        .cdb_src      (cdb_src)
    );

    always #5 clk = ~clk;

    function automatic logic [0:3] onehot(input int i);
        logic [0:3] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_unit(input int u, input logic [4:0] rs, input logic [4:0] ra,
                            input logic [31:0] res, input logic [6:0] ce);
        unit_rs_id[u]    = rs;
        unit_reg_addr[u] = ra;
        unit_result[u]   = res;
        unit_cr0_xer[u]  = ce;
    endtask

    task automatic clear_inputs();
        unit_valid    = '0;
        unit_rs_id    = '0;
        unit_reg_addr = '0;
        unit_result   = '0;
        unit_cr0_xer  = '0;
        cdb_ready     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        unit_valid = 4'b1111;
        cdb_ready  = 1'b1;
        #1;
        total++;
        if (unit_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_unit_ready: got %b want 0000", unit_ready);
        end
        step();
        unit_valid = '0;
        step();
        rst = 1'b1;
        mid();
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_cdb_valid: got %b want 0", cdb_valid);
        end
        total++;
        if (cdb_rs_id !== 5'd0 || cdb_reg_addr !== 5'd0) begin
            bad++;
            $display("FAIL reset_ids: got rs=%0d reg=%0d want 0/0", cdb_rs_id, cdb_reg_addr);
        end
        total++;
        if (cdb_result !== 32'd0) begin
            bad++;
            $display("FAIL reset_result: got %h want 0", cdb_result);
        end
        total++;
        if (cdb_src !== 2'd0 || cdb_cr0_xer !== 7'd0) begin
            bad++;
            $display("FAIL reset_src_cr: got src=%0d cr=%b want 0/0", cdb_src, cdb_cr0_xer);
        end
    endtask

    task automatic test_single();
        do_reset();
        cdb_ready = 1'b1;
        set_unit(2, 5'd7, 5'd3, 32'hDEADBEEF, 7'b1010_101);
        unit_valid[2] = 1'b1;
        mid();
        total++;
        if (unit_ready !== onehot(2)) begin
            bad++;
            $display("FAIL single_ready: got %b want %b", unit_ready, onehot(2));
        end
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_no_early: got cdb_valid %b want 0", cdb_valid);
        end
        step();
        unit_valid[2] = 1'b0;
        mid();
        total++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd2) begin
            bad++;
            $display("FAIL single_valid_src: got v=%b src=%0d want 1/2", cdb_valid, cdb_src);
        end
        total++;
        if (cdb_rs_id !== 5'd7 || cdb_reg_addr !== 5'd3) begin
            bad++;
            $display("FAIL single_ids: got rs=%0d reg=%0d want 7/3", cdb_rs_id, cdb_reg_addr);
        end
        total++;
        if (cdb_result !== 32'hDEADBEEF || cdb_cr0_xer !== 7'b1010_101) begin
            bad++;
            $display("FAIL single_data: got %h cr=%b want deadbeef cr=1010101", cdb_result, cdb_cr0_xer);
        end
        step();
        mid();
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_idle: got cdb_valid %b want 0", cdb_valid);
        end
    endtask

    task automatic test_all_valid();
        int exp_src;
        do_reset();
        cdb_ready = 1'b1;
        for (int u = 0; u < 4; u++) begin
            set_unit(u, 5'(u + 1), 5'(u + 10), 32'h1000_0000 + 32'(u), 7'(u));
        end
        unit_valid = 4'b1111;
        mid();
        total++;
        if (unit_ready !== onehot(0)) begin
            bad++;
            $display("FAIL all_first_ready: got %b want %b", unit_ready, onehot(0));
        end
        step();
        for (int i = 0; i < 6; i++) begin
            exp_src = RR ? (i % 4) : 0;
            mid();
            total++;
            if (cdb_valid !== 1'b1 || cdb_src !== 2'(exp_src) ||
                cdb_result !== 32'h1000_0000 + 32'(exp_src)) begin
                bad++;
                $display("FAIL all_seq%0d: got v=%b src=%0d res=%h want v=1 src=%0d", i,
                         cdb_valid, cdb_src, cdb_result, exp_src);
            end
            step();
        end
        unit_valid = '0;
    endtask

    task automatic test_backpressure();
        do_reset();
        cdb_ready = 1'b1;
        set_unit(0, 5'd9, 5'd4, 32'hA5A5_0000, 7'b0100_010);
        unit_valid[0] = 1'b1;
        step();
        unit_valid[0] = 1'b0;
        cdb_ready = 1'b0;
        set_unit(1, 5'd17, 5'd30, 32'h1234_5678, 7'b0001_001);
        unit_valid[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            total++;
            if (cdb_valid !== 1'b1 || cdb_src !== 2'd0 || cdb_rs_id !== 5'd9 ||
                cdb_result !== 32'hA5A5_0000 || cdb_cr0_xer !== 7'b0100_010) begin
                bad++;
                $display("FAIL stall_hold%0d: got v=%b src=%0d rs=%0d res=%h want 1/0/9/a5a50000",
                         i, cdb_valid, cdb_src, cdb_rs_id, cdb_result);
            end
            total++;
            if (unit_ready !== 4'b0000) begin
                bad++;
                $display("FAIL stall_ready%0d: got %b want 0000", i, unit_ready);
            end
            step();
        end
        cdb_ready = 1'b1;
        mid();
        total++;
        if (unit_ready !== onehot(1)) begin
            bad++;
            $display("FAIL drain_ready: got %b want %b", unit_ready, onehot(1));
        end
        step();
        unit_valid[1] = 1'b0;
        mid();
        total++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_rs_id !== 5'd17 ||
            cdb_reg_addr !== 5'd30 || cdb_result !== 32'h1234_5678) begin
            bad++;
            $display("FAIL drain_next: got v=%b src=%0d rs=%0d res=%h want 1/1/17/12345678",
                     cdb_valid, cdb_src, cdb_rs_id, cdb_result);
        end
        step();
    endtask

    task automatic test_wrap();
        int first;
        int second;
        first  = RR ? 3 : 0;
        second = RR ? 0 : 3;
        do_reset();
        cdb_ready = 1'b1;
        set_unit(2, 5'd2, 5'd2, 32'h0000_00C2, 7'd0);
        unit_valid[2] = 1'b1;
        step();
        unit_valid[2] = 1'b0;
        set_unit(0, 5'd20, 5'd1, 32'h0000_00C0, 7'd0);
        set_unit(3, 5'd23, 5'd5, 32'h0000_00C3, 7'd0);
        unit_valid[0] = 1'b1;
        unit_valid[3] = 1'b1;
        mid();
        total++;
        if (unit_ready !== onehot(first)) begin
            bad++;
            $display("FAIL wrap_ready1: got %b want %b", unit_ready, onehot(first));
        end
        step();
        unit_valid[first] = 1'b0;
        mid();
        total++;
        if (cdb_src !== 2'(first) || cdb_result !== 32'h0000_00C0 + 32'(first)) begin
            bad++;
            $display("FAIL wrap_grant1: got src=%0d res=%h want src=%0d", cdb_src, cdb_result, first);
        end
        total++;
        if (unit_ready !== onehot(second)) begin
            bad++;
            $display("FAIL wrap_ready2: got %b want %b", unit_ready, onehot(second));
        end
        step();
        unit_valid[second] = 1'b0;
        mid();
        total++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'(second)) begin
            bad++;
            $display("FAIL wrap_grant2: got v=%b src=%0d want 1/%0d", cdb_valid, cdb_src, second);
        end
        step();
    endtask

    task automatic test_async_reset();
        do_reset();
        cdb_ready = 1'b1;
        set_unit(1, 5'd11, 5'd6, 32'hCAFE_0001, 7'b1111_111);
        unit_valid[1] = 1'b1;
        step();
        unit_valid[1] = 1'b0;
        cdb_ready = 1'b0;
        mid();
        total++;
        if (cdb_valid !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre: got cdb_valid %b want 1", cdb_valid);
        end
        unit_valid[3] = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (cdb_valid !== 1'b0 || cdb_result !== 32'd0 || cdb_src !== 2'd0) begin
            bad++;
            $display("FAIL arst_clear: got v=%b res=%h src=%0d want 0/0/0", cdb_valid, cdb_result, cdb_src);
        end
        total++;
        if (unit_ready !== 4'b0000) begin
            bad++;
            $display("FAIL arst_ready: got %b want 0000", unit_ready);
        end
        unit_valid[3] = 1'b0;
        #1;
        rst = 1'b1;
        step();
        cdb_ready = 1'b1;
        set_unit(3, 5'd13, 5'd7, 32'hCAFE_0003, 7'd0);
        unit_valid[1] = 1'b1;
        unit_valid[3] = 1'b1;
        mid();
        total++;
        if (unit_ready !== onehot(1)) begin
            bad++;
            $display("FAIL arst_ready_after: got %b want %b", unit_ready, onehot(1));
        end
        step();
        unit_valid[1] = 1'b0;
        mid();
        total++;
        if (cdb_valid !== 1'b1 || cdb_src !== 2'd1 || cdb_result !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL arst_first_grant: got v=%b src=%0d res=%h want 1/1/cafe0001",
                     cdb_valid, cdb_src, cdb_result);
        end
        step();
        unit_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_valid();
        test_backpressure();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
